// File: rtl/key_pkg.sv
// Shared definitions for the push-button debouncer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: per-channel FSM state encoding and default timing constants
// for a 50 MHz core clock (20 ms debounce, 1 s long-press).
package key_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } key_state_t;

    localparam int KEY_DEBOUNCE_CYCLES = 1000000;
    localparam int KEY_LONG_CYCLES     = 50000000;

endpackage

// File: rtl/key_debounce_ch.sv
// One-key debouncer: 2-flop synchronizer, 4-state FSM, shared counter, pulse flops.
// Latency: press/release reported DEBOUNCE_CYCLES+3 edges after a stable level change.
// Backpressure: none; pulses are fire-and-forget single-cycle strobes.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   key_n       raw asynchronous button, 0 = pressed
//   key_level   debounced level, 1 = pressed (registered)
//   key_press   one-cycle pulse on debounced press
//   key_release one-cycle pulse on debounced release
//   key_long    one-cycle pulse once per press after LONG_CYCLES held
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = KEY_LONG_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    // LONG_CYCLES-1 always fits in $clog2(LONG_CYCLES) bits, and the
    // counter saturates there, so it can never wrap.
    localparam int CNT_W = $clog2(LONG_CYCLES);
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    key_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_long_done;
    logic             r_level;
    logic             r_press;
    logic             r_release;
    logic             r_long;
    logic             w_pressed;

    assign w_pressed = ~r_sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            // Synchronizer parks at "released" so a key held through reset
            // is seen as a fresh falling edge afterwards.
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_long_done <= 1'b0;
            r_level     <= 1'b0;
            r_press     <= 1'b0;
            r_release   <= 1'b0;
            r_long      <= 1'b0;
        end else begin
            r_sync1   <= key_n;
            r_sync2   <= r_sync1;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_long    <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_pressed) begin
                        r_state <= ST_PRESS_WAIT;
                        r_cnt   <= '0;
                    end
                end

                ST_PRESS_WAIT: begin
                    if (!w_pressed) begin
                        // Bounce rejected silently.
                        r_state     <= ST_IDLE;
                        r_cnt       <= '0;
                        r_long_done <= 1'b0;
                    end else if (r_cnt == DB_LAST) begin
                        r_state <= ST_PRESSED;
                        r_cnt   <= '0;
                        r_press <= 1'b1;
                        r_level <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                ST_PRESSED: begin
                    if (!w_pressed) begin
                        r_state <= ST_RELEASE_WAIT;
                        r_cnt   <= '0;
                    end else if (r_cnt == LONG_LAST) begin
                        // Counter holds at its ceiling; long_done keeps
                        // the strobe to a single pulse per press.
                        if (!r_long_done) begin
                            r_long      <= 1'b1;
                            r_long_done <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                ST_RELEASE_WAIT: begin
                    if (w_pressed) begin
                        // Release glitch: back to held, long timer restarts
                        // but an already-fired long press is not re-armed.
                        r_state <= ST_PRESSED;
                        r_cnt   <= '0;
                    end else if (r_cnt == DB_LAST) begin
                        r_state     <= ST_IDLE;
                        r_cnt       <= '0;
                        r_long_done <= 1'b0;
                        r_release   <= 1'b1;
                        r_level     <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign key_level   = r_level;
    assign key_press   = r_press;
    assign key_release = r_release;
    assign key_long    = r_long;

endmodule

// File: rtl/key_debounce.sv
// N_KEYS independent push-button debouncers with press/release/long-press strobes.
// Latency: DEBOUNCE_CYCLES+3 edges from stable level change to pulse/level update.
// Backpressure: none; all strobes are registered single-cycle enables in the clk domain.
//
// Ports:
//   clk               rising-edge clock
//   rst               synchronous active-high reset
//   key_n[N_KEYS]     raw asynchronous buttons, 0 = pressed
//   key_level[N_KEYS] debounced level, 1 = pressed
//   key_press[N_KEYS] one-cycle press strobe per key
//   key_release[N_KEYS] one-cycle release strobe per key
//   key_long[N_KEYS]  one-cycle long-press strobe per key
module key_debounce
    import key_pkg::*;
#(
    parameter int N_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = KEY_LONG_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_n,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_long
);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("key_debounce: DEBOUNCE_CYCLES must be at least 2");
    end
    if (LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_long
        $error("key_debounce: LONG_CYCLES must exceed DEBOUNCE_CYCLES");
    end

    for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .key_n       (key_n[g]),
            .key_level   (key_level[g]),
            .key_press   (key_press[g]),
            .key_release (key_release[g]),
            .key_long    (key_long[g])
        );
    end

endmodule

// File: tb/tb_key_debounce.sv
// Directed testbench for key_debounce with DEBOUNCE_CYCLES=4, LONG_CYCLES=20.
// Inputs change 1 time unit after a rising edge; outputs are checked at that point.
module tb_key_debounce;

    localparam int N  = 4;
    localparam int DB = 4;
    localparam int LG = 20;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] key_n;
    logic [N-1:0] key_level;
    logic [N-1:0] key_press;
    logic [N-1:0] key_release;
    logic [N-1:0] key_long;

    int n_chk = 0;
    int n_err = 0;

    int press_cnt   [N] = '{0, 0, 0, 0};
    int release_cnt [N] = '{0, 0, 0, 0};
    int long_cnt    [N] = '{0, 0, 0, 0};
    int both_cnt        = 0;

    key_debounce #(
        .N_KEYS          (N),
        .DEBOUNCE_CYCLES (DB),
        .LONG_CYCLES     (LG)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_n       (key_n),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long)
    );

    always #5 clk = ~clk;

    // Pulse tally, sampled mid-cycle.
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (key_press[i])   press_cnt[i]++;
            if (key_release[i]) release_cnt[i]++;
            if (key_long[i])    long_cnt[i]++;
            if (key_press[i] && key_release[i]) both_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // n edges with no pulses anywhere and a fixed debounced level.
    task automatic quiet(input string tag, input int n, input logic [N-1:0] lvl);
        for (int k = 0; k < n; k++) begin
            tick();
            check({tag, "_pulses"}, {20'd0, key_press, key_release, key_long}, 32'd0);
            check({tag, "_level"}, {28'd0, key_level}, {28'd0, lvl});
        end
    endtask

    // One edge with expected pulses and level.
    task automatic step(input string tag, input logic [N-1:0] p, input logic [N-1:0] r,
                        input logic [N-1:0] l, input logic [N-1:0] lvl);
        tick();
        check({tag, "_press"},   {28'd0, key_press},   {28'd0, p});
        check({tag, "_release"}, {28'd0, key_release}, {28'd0, r});
        check({tag, "_long"},    {28'd0, key_long},    {28'd0, l});
        check({tag, "_level"},   {28'd0, key_level},   {28'd0, lvl});
    endtask

    initial begin
        rst   = 1'b1;
        key_n = 4'hF;

        // Reset state
        tick(); tick(); tick();
        step("reset", 4'h0, 4'h0, 4'h0, 4'h0);
        rst = 1'b0;
        quiet("idle", 3, 4'h0);

        // Clean press/release on key 0: pulse on the 7th edge
        key_n[0] = 1'b0;
        quiet("clean_wait", 6, 4'h0);
        step("clean_press", 4'b0001, 4'h0, 4'h0, 4'b0001);
        key_n[0] = 1'b1;
        quiet("clean_hold", 6, 4'b0001);
        step("clean_release", 4'h0, 4'b0001, 4'h0, 4'h0);
        quiet("gap1", 3, 4'h0);

        // Bounce on key 1: 3 low, 2 high, then stable low
        key_n[1] = 1'b0;
        quiet("bounce_low", 3, 4'h0);
        key_n[1] = 1'b1;
        quiet("bounce_high", 2, 4'h0);
        key_n[1] = 1'b0;
        quiet("bounce_wait", 6, 4'h0);
        step("bounce_press", 4'b0010, 4'h0, 4'h0, 4'b0010);
        key_n[1] = 1'b1;
        quiet("bounce_hold", 6, 4'b0010);
        step("bounce_release", 4'h0, 4'b0010, 4'h0, 4'h0);
        quiet("gap2", 3, 4'h0);

        // Long hold on key 2: 40 edges low, long fires 20 edges after press
        key_n[2] = 1'b0;
        quiet("long_wait", 6, 4'h0);
        step("long_press", 4'b0100, 4'h0, 4'h0, 4'b0100);
        quiet("long_count", 19, 4'b0100);
        step("long_fire", 4'h0, 4'h0, 4'b0100, 4'b0100);
        quiet("long_sat", 13, 4'b0100);
        key_n[2] = 1'b1;
        quiet("long_rel_wait", 6, 4'b0100);
        step("long_release", 4'h0, 4'b0100, 4'h0, 4'h0);
        quiet("gap3", 3, 4'h0);

        // Release glitch on key 3 while pressed
        key_n[3] = 1'b0;
        quiet("glitch_wait", 6, 4'h0);
        step("glitch_press", 4'b1000, 4'h0, 4'h0, 4'b1000);
        quiet("glitch_held", 3, 4'b1000);
        key_n[3] = 1'b1;
        quiet("glitch_high", 2, 4'b1000);
        key_n[3] = 1'b0;
        quiet("glitch_after", 10, 4'b1000);
        key_n[3] = 1'b1;
        quiet("glitch_rel_wait", 6, 4'b1000);
        step("glitch_release", 4'h0, 4'b1000, 4'h0, 4'h0);
        quiet("gap4", 3, 4'h0);

        // Reset mid-operation: key 2 pressed, key 0 mid-debounce
        key_n[2] = 1'b0;
        quiet("rst_k2_wait", 6, 4'h0);
        step("rst_k2_press", 4'b0100, 4'h0, 4'h0, 4'b0100);
        key_n[0] = 1'b0;
        quiet("rst_k0_wait", 4, 4'b0100);
        rst = 1'b1;
        step("rst_mid", 4'h0, 4'h0, 4'h0, 4'h0);
        rst = 1'b0;
        quiet("rst_after", 6, 4'h0);
        step("rst_repress", 4'b0101, 4'h0, 4'h0, 4'b0101);
        key_n = 4'hF;
        quiet("rst_rel_wait", 6, 4'b0101);
        step("rst_release", 4'h0, 4'b0101, 4'h0, 4'h0);
        quiet("gap5", 3, 4'h0);

        // Concurrent presses on keys 0 and 3
        key_n = 4'b0110;
        quiet("conc_wait", 6, 4'h0);
        step("conc_press", 4'b1001, 4'h0, 4'h0, 4'b1001);
        key_n = 4'hF;
        quiet("conc_rel_wait", 6, 4'b1001);
        step("conc_release", 4'h0, 4'b1001, 4'h0, 4'h0);
        quiet("gap6", 3, 4'h0);

        // Pulse totals over the whole run
        check("press_cnt0",   press_cnt[0],   3);
        check("press_cnt1",   press_cnt[1],   1);
        check("press_cnt2",   press_cnt[2],   3);
        check("press_cnt3",   press_cnt[3],   2);
        check("release_cnt0", release_cnt[0], 3);
        check("release_cnt1", release_cnt[1], 1);
        check("release_cnt2", release_cnt[2], 2);
        check("release_cnt3", release_cnt[3], 2);
        check("long_cnt0",    long_cnt[0],    0);
        check("long_cnt1",    long_cnt[1],    0);
        check("long_cnt2",    long_cnt[2],    1);
        check("long_cnt3",    long_cnt[3],    0);
        check("press_and_release_together", both_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 SHALL have parameter N_KEYS, default 4, number of independent key channels.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, stable-level time in clk cycles (20 ms at 50 MHz).
REQ-003 SHALL have parameter LONG_CYCLES, default 50000000, hold time in clk cycles before key_long fires (1 s at 50 MHz).
REQ-004 SHALL have port clk  input  1  system clock; one clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port key_n  input  N_KEYS  raw asynchronous push-buttons, active-low (0 = pressed).
REQ-007 SHALL have port key_level  output  N_KEYS  debounced level, 1 = pressed.
REQ-008 SHALL have port key_press  output  N_KEYS  one-cycle pulse per debounced press.
REQ-009 SHALL have port key_release  output  N_KEYS  one-cycle pulse per debounced release.
REQ-010 SHALL have port key_long  output  N_KEYS  one-cycle pulse, at most once per press, after LONG_CYCLES held.

Function
REQ-011 Each key_n bit SHALL pass through a 2-flop synchronizer before any use; channels fully independent.
REQ-012 Per-channel FSM states SHALL be IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-013 IDLE: synced pressed -> PRESS_WAIT, cnt=0; else stay.
REQ-014 PRESS_WAIT: synced released -> IDLE, no pulse (bounce rejected); cnt==DEBOUNCE_CYCLES-1 -> PRESSED, cnt=0, key_press=1 next cycle; else cnt+1.
REQ-015 PRESSED: synced released -> RELEASE_WAIT, cnt=0; else cnt increments, saturating at LONG_CYCLES-1.
REQ-016 In PRESSED, cnt==LONG_CYCLES-1 with long_done=0 SHALL pulse key_long one cycle and set long_done; long_done clears only on entry to IDLE.
REQ-017 RELEASE_WAIT: synced pressed -> PRESSED, no pulse, cnt=0 (long count restarts, long_done kept); cnt==DEBOUNCE_CYCLES-1 -> IDLE, key_release=1 next cycle; else cnt+1.
REQ-018 key_level SHALL be 1 exactly while state is PRESSED or RELEASE_WAIT (registered, changes same edge as key_press/key_release).
REQ-019 Press latency SHALL be exactly DEBOUNCE_CYCLES+3 rising edges from the first edge sampling key_n low (stable); release latency identical.
REQ-020 All pulse outputs SHALL be registered and high for exactly one cycle; key_press and key_release never high together on one channel.
REQ-021 Counter width SHALL be $clog2(LONG_CYCLES); no wrap-around permitted anywhere.
REQ-022 Simultaneous events on different channels SHALL each produce their own pulses in the same cycle.

Reset
REQ-023 rst high at any clock edge SHALL force synchronizer flops to 1 (released), all FSMs to IDLE, cnt=0, long_done=0, all outputs 0, including mid-debounce or mid-press.
REQ-024 A key held during and after reset release SHALL be debounced as a fresh press (key_press fires per REQ-019 timing measured from first post-reset edge).

Structure
REQ-025 Shared package key_pkg SHALL hold the FSM state enum and default timing constants (DEBOUNCE_CYCLES, LONG_CYCLES at 50 MHz).
REQ-026 One sub-module key_debounce_ch (synchronizer, FSM, counter, pulse flops for one key) SHALL be instantiated N_KEYS times via generate.
REQ-027 Elaboration SHALL reject DEBOUNCE_CYCLES<2 or LONG_CYCLES<=DEBOUNCE_CYCLES.
REQ-028 Outputs key_press/key_long SHALL be directly usable as clock enables by the LED pattern stage (no derived clocks).

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=20, N_KEYS=4)
REQ-029 Clean press: key_n[0] 1->0 held -> key_press[0] high exactly one cycle after 7th edge, key_level[0]=1 from same edge.
REQ-030 Bounce: key_n[1] low 3 cycles, high 2, low stable -> no pulse for the 3-cycle glitch; single key_press[1] 7 edges after final fall.
REQ-031 Long hold: key_n[2] low 40 cycles -> one key_press[2], exactly one key_long[2] 20 cycles after press, then one key_release[2] 7 edges after rise.
REQ-032 Release glitch: during PRESSED, key_n[3] high 2 cycles -> no key_release, no second key_press, key_level stays 1.
REQ-033 Reset mid-operation: rst high one cycle during PRESS_WAIT of key 0 with key held -> all outputs 0, then key_press[0] 7 edges after rst low.
REQ-034 Concurrency: keys 0 and 3 pressed on same edge -> key_press[0] and key_press[3] asserted in the same cycle.
